// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI initiator and its timeout counter.
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic        wr;
    logic        illegal;
    logic [31:0] rd;
  } resp_t;

  // True when the word is an R-type MUL/DIV encoding (the M-unit's space).
  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/m_pcpi_timeout.sv
// Saturating cycle counter used to detect an unclaimed PCPI instruction.
// It counts up to TIMEOUT_CYCLES-1 and then holds, so it can never wrap.
module m_pcpi_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  // Clear dominates; otherwise count while enabled and hold at the last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/m_pcpi_initiator.sv
// CPU-side PCPI initiator: accepts one instruction from the requester, holds
// it on the PCPI bus until a responder answers or the busy-aware timeout
// flags it illegal, then buffers the response until the requester takes it.
module m_pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_wr,
  output logic [31:0] resp_rd,
  output logic        resp_illegal,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_busy,
  input  logic        pcpi_ready
);

  state_e      state;
  resp_t       resp_q;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        pcpi_valid_q;

  logic        in_issue;
  logic        tmr_clear;
  logic        tmr_enable;
  logic        tmr_expired;
  logic        timeout_hit;

  // The timer only runs while the request is on the bus; a busy responder
  // keeps it at zero, and it is zeroed in IDLE so each issue starts fresh.
  assign in_issue    = (state == ISSUE);
  assign tmr_clear   = (state == IDLE) || (in_issue && pcpi_busy);
  assign tmr_enable  = in_issue;
  assign timeout_hit = in_issue && tmr_expired && !pcpi_busy && !pcpi_ready;

  m_pcpi_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Request/response FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      pcpi_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      resp_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            insn_q       <= req_insn;
            rs1_q        <= req_rs1;
            rs2_q        <= req_rs2;
            req_ready_q  <= 1'b0;
            pcpi_valid_q <= 1'b1;
            state        <= ISSUE;
          end else begin
            req_ready_q  <= 1'b1;
          end
        end
        ISSUE: begin
          // A result arriving in the terminal timer cycle still wins.
          if (pcpi_ready) begin
            resp_q.wr      <= pcpi_wr;
            resp_q.rd      <= pcpi_rd;
            resp_q.illegal <= 1'b0;
            pcpi_valid_q   <= 1'b0;
            resp_valid_q   <= 1'b1;
            state          <= RESP;
          end else if (timeout_hit) begin
            resp_q.wr      <= 1'b0;
            resp_q.rd      <= '0;
            resp_q.illegal <= 1'b1;
            pcpi_valid_q   <= 1'b0;
            resp_valid_q   <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          pcpi_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_wr      = resp_q.wr;
  assign resp_rd      = resp_q.rd;
  assign resp_illegal = resp_q.illegal;
  assign pcpi_valid   = pcpi_valid_q;
  assign pcpi_insn    = insn_q;
  assign pcpi_rs1     = rs1_q;
  assign pcpi_rs2     = rs2_q;

endmodule

// File: doc/m_pcpi_initiator.md
Name: m_pcpi_initiator

Overview:
CPU-side PCPI initiator that issues one co-processor instruction at a time to a PCPI responder such as the M-unit, and returns the result to a requester. The requester is the core's execute stage or a test driver. The block registers the request, holds pcpi_valid with stable operands until the responder answers, and applies a busy-aware timeout that flags illegal instructions. It buffers the response until the requester accepts it.

Parameters:
TIMEOUT_CYCLES, 16, cycles of pcpi_valid high with pcpi_busy low and no pcpi_ready before the request is declared illegal (minimum 2)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
req_valid  input  1  requester has an instruction
req_ready  output  1  initiator can accept a request
req_insn  input  32  instruction word
req_rs1  input  32  rs1 operand value
req_rs2  input  32  rs2 operand value
resp_valid  output  1  response available
resp_ready  input  1  requester accepts response
resp_wr  output  1  result must be written to rd
resp_rd  output  32  result value
resp_illegal  output  1  no responder claimed the instruction (timeout)
pcpi_valid  output  1  PCPI request valid
pcpi_insn  output  32  PCPI instruction
pcpi_rs1  output  32  PCPI rs1
pcpi_rs2  output  32  PCPI rs2
pcpi_wr  input  1  responder write enable
pcpi_rd  input  32  responder result
pcpi_busy  input  1  responder has claimed the instruction and is working
pcpi_ready  input  1  responder result valid this cycle

Behaviour:
- Reset values: every output is 0, and the state is IDLE. Async reset asserted mid-operation aborts the operation: no response is produced and pcpi_valid drops at once.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch insn/rs1/rs2 into registers, clear the timer, go to ISSUE.
  - ISSUE: pcpi_valid=1, and pcpi_insn/rs1/rs2 are driven from the registers and are constant for the whole state.
    - Timer: cleared on any cycle with pcpi_busy=1. Otherwise it increments each cycle.
    - pcpi_ready=1: capture resp_wr=pcpi_wr and resp_rd=pcpi_rd, set resp_illegal=0, go to RESP. pcpi_valid is 0 the following cycle.
    - Timeout: timer reaches TIMEOUT_CYCLES-1 with pcpi_busy=0 and pcpi_ready=0 → resp_illegal=1, resp_wr=0, resp_rd=0, go to RESP.
    - Priority: pcpi_ready beats timeout in the same cycle. pcpi_busy=1 in the terminal cycle cancels the timeout.
  - RESP: resp_valid=1 and the response fields are stable. On resp_ready, go to IDLE, where resp_valid=0.
- req_ready=0 in ISSUE and RESP; the request is not accepted in the same cycle a response retires.
- Latency:
  - Accept edge → pcpi_valid high on the next cycle.
  - pcpi_ready cycle → resp_valid high on the next cycle.
  - Minimum issue-to-issue spacing is 3 cycles.
- pcpi_ready or pcpi_wr outside ISSUE is ignored; no state change.
- pcpi_rd is sampled only in the pcpi_ready cycle. Later changes do not affect resp_rd.
- A long busy period never times out: the M-unit divide takes about 32+ cycles with busy high.
- pcpi_busy dropping without ready restarts the timeout count from 0.
- Timer width is $clog2(TIMEOUT_CYCLES); the timer saturates and never wraps.

Decomposition:
- Shared package pcpi_pkg holds:
  - state enum typedef (IDLE, ISSUE, RESP);
  - opcode constants OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001;
  - a response struct typedef {wr, illegal, rd}.
- One natural sub-module: m_pcpi_timeout, the saturating counter with clear/enable/expired outputs.

Test Plan:
- MUL 7×6: req_insn=0x022081B3, rs1=7, rs2=6; stub responder with busy for 3 cycles then ready, wr=1, rd=42 → resp_valid one cycle after ready, resp_wr=1, resp_rd=42, resp_illegal=0. pcpi_valid stays high for exactly the issue window.
- Illegal instruction: req_insn=0x00000013, responder silent → resp_illegal=1, resp_wr=0, resp_rd=0, with resp_valid rising exactly 16 cycles after pcpi_valid rose (TIMEOUT_CYCLES=16).
- Long divide: busy high 40 cycles, then ready with rd=0xFFFFFFFF → no timeout, resp_rd=0xFFFFFFFF.
- Ready and timeout in the same cycle: ready asserted exactly at timer=15 → resp_illegal=0 and the result is taken.
- Backpressure: resp_ready low for 5 cycles → resp fields stable and req_ready=0 throughout; a new req_valid is accepted only after retire.
- Reset mid-ISSUE: resetn low while busy=1 → pcpi_valid=0 and all outputs 0 immediately. After release, a new MUL 3×5 returns rd=15.
